// File: rtl/bitwise_arb_pkg.sv
// Shared types for the two-port bitwise logic arbiter: op codes, FSM states, port ids.
package bitwise_arb_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/bitwise_arbiter_if.sv
// Request/response bundle between the two requesters and the shared bitwise unit.
interface bitwise_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp0_ready;
    logic             resp1_ready;
    logic [CNT_W-1:0] ops_done;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, ops_done
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, ops_done
    );

endinterface

// File: rtl/bitwise_unit.sv
// Combinational bitwise logic unit; XOR and NOR are derived from the shared AND/OR terms.
module bitwise_unit
    import bitwise_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;

    assign and_v = a & b;
    assign or_v  = a | b;

    always_comb begin
        y = and_v;
        unique case (op)
            OP_AND: y = and_v;
            OP_OR:  y = or_v;
            OP_XOR: y = or_v & ~and_v;
            OP_NOR: y = ~or_v;
            default: y = and_v;
        endcase
    end

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter sharing one bitwise_unit between two requesters, with a held response.
module bitwise_arbiter
    import bitwise_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    bitwise_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic grant0, grant1;
    logic resp_fire, can_accept;
    logic ready0, ready1;

    // Grant is recomputed every cycle; ties go to the port not granted last.
    always_comb begin
        grant0     = bus.req0_valid & (~bus.req1_valid | (last_grant_q == PORT1));
        grant1     = bus.req1_valid & (~bus.req0_valid | (last_grant_q == PORT0));
        resp_fire  = (state_q == ST_RESP) &
                     ((id_q == PORT1) ? bus.resp1_ready : bus.resp0_ready);
        can_accept = (state_q == ST_IDLE) | resp_fire;
        ready0     = grant0 & can_accept;
        ready1     = grant1 & can_accept;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        ops_done_d   = ops_done_q;

        if (ready1) begin
            id_d         = PORT1;
            op_d         = op_e'(bus.req1_op);
            a_d          = bus.req1_a;
            b_d          = bus.req1_b;
            last_grant_d = PORT1;
            state_d      = ST_RESP;
        end else if (ready0) begin
            id_d         = PORT0;
            op_d         = op_e'(bus.req0_op);
            a_d          = bus.req0_a;
            b_d          = bus.req0_b;
            last_grant_d = PORT0;
            state_d      = ST_RESP;
        end else if (resp_fire) begin
            state_d = ST_IDLE;
        end

        if (resp_fire) begin
            ops_done_d = ops_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT1;
            id_q         <= PORT0;
            op_q         <= OP_AND;
            a_q          <= '0;
            b_q          <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // Result is computed from the latched operands only, so no operand-to-output path exists.
    logic [WIDTH-1:0] result;

    bitwise_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (result)
    );

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_data  = result;
    assign bus.ops_done   = ops_done_q;

endmodule

// File: doc/bitwise_arbiter.md
# bitwise_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, the execute stage (port 0) and the multdiv sequencer (port 1). It uses a valid/ready request handshake, round-robin arbitration and a registered result held until the owning requester accepts it. The block sits beside the ALU in the multdiv datapath, so iterative multdiv steps can issue logic ops without stalling the pipeline ALU.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of the completed-operation counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op, req1_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- resp_valid  out  1  result held for requester resp_id
- resp_id  out  1  owner of current result
- resp_data  out  WIDTH  result
- resp0_ready, resp1_ready  in  1  requester accepts result; only resp_id's ready is honoured
- ops_done  out  CNT_W  count of completed responses

## Operation
- States: IDLE (no result held) and RESP (result held, resp_valid=1).
- Arbitration: grant goes to the sole valid requester. If both are valid, grant goes to the requester not granted last (last_grant register). last_grant resets to 1, so port 0 wins the first tie.
- The grant is recomputed every cycle from the current valids. It does not latch while waiting.
- Accept condition: ready_i = grant_i & (state==IDLE | resp_fire). resp_fire = resp_valid & resp{resp_id}_ready.
- On accept: latch op, a, b and id, update last_grant to id, enter/stay in RESP.
- In RESP: resp_data = bitwise_unit(latched op, a, b). resp_id = latched id.
- RESP with resp_fire and no accept: go to IDLE. ops_done += 1 on every resp_fire, wrapping modulo 2^CNT_W.
- Response of the non-owner ready is ignored. The result is never dropped except by reset.
- Requesters must hold valid and payload stable until ready. Deasserting an unaccepted valid is legal and simply withdraws the request.
- Arithmetic: pure bitwise, no carries. NOR = ~(a|b). XOR = (a|b)&~(a&b).

## Timing
- Reset values: req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_data=0, ops_done=0, state=IDLE, last_grant=1.
- req_ready is combinational from req valids, state and resp ready. There is no combinational path from operands to outputs.
- Latency: accepted at edge N, resp_valid=1 after edge N, visible in cycle N+1.
- Throughput: one op per cycle when the owner holds resp ready high. A new request is accepted in the same cycle the previous response fires.
- Backpressure: when the owner's resp ready is low, both req_ready stay 0 and resp_data and resp_id stay stable.
- Reset mid-RESP: asynchronously return to IDLE. The held result is discarded and ops_done clears.
- Simultaneous valids during RESP without fire: no grant is consumed, so last_grant is unchanged.

## Structure
- Package bitwise_arb_pkg: op codes OP_AND/OP_OR/OP_XOR/OP_NOR (2-bit), state enum ST_IDLE/ST_RESP, PORT0/PORT1 ids.
- Sub-module bitwise_unit: combinational, inputs op/a/b, output y. It is built from the team's 32-bit bitwise AND and OR components plus inversion.
- Arbiter, FSM, operand registers and counter live in bitwise_arbiter.

## Test plan
- Reset then idle: all outputs 0. Assert reset mid-RESP → resp_valid falls immediately and ops_done=0.
- req0 alone, op OR, a=0x0000_F0F0, b=0x0F0F_0000, resp0_ready=1 → req0_ready=1 in cycle 0. Cycle 1: resp_valid=1, resp_id=0, resp_data=0x0F0F_F0F0. ops_done=1.
- Both valid every cycle with both resp ready high, ops XOR (req0) / NOR (req1), a=0xFFFF_0000, b=0xFF00_FF00 → grants alternate 0,1,0,1. resp_data alternates 0x00FF_FF00 and 0x0000_00FF. ops_done increments every cycle.
- Backpressure: result held for id 1 with resp1_ready=0 for 3 cycles and req0_valid=1 → req0_ready=0 throughout and resp_data stable. resp0_ready=1 is ignored. Raising resp1_ready accepts req0 in the same cycle.
- AND 0x1234_5678 & 0x0F0F_0F0F → 0x0204_0608. NOR 0 with 0 → 0xFFFF_FFFF.
- Counter wrap: force 2^CNT_W−1 completions → ops_done returns to 0 on the next fire.
